// File: rtl/apb_master_bridge.sv
// Bridges a valid/ready request/response interface onto an APB4 master port.
// Define APB_TIMEOUT_EN to abort transfers that wait more than TIMEOUT cycles.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH/8-1:0]   PSTRB,
    input  logic                      PREADY,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e state_q;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

    logic [CNT_WIDTH-1:0] waitCnt_q;
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT != 0);
`endif

    // Only unregistered output; held low while reset is asserted.
    assign req_ready = (state_q == IDLE) && !PRESET;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            waitCnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        PWRITE  <= req_write;
                        PADDR   <= req_addr;
                        PWDATA  <= req_write ? req_wdata : '0;
                        PSTRB   <= req_write ? req_strb : '0;
                        PSEL    <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state_q <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    waitCnt_q <= '0;
`endif
                end
                ACCESS: begin
                    // Slave data is only trusted on the PSEL/PENABLE/PREADY completion beat.
                    if (PSEL && PENABLE && PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state_q   <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (waitCnt_q == CNT_LIMIT) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a small memory-backed APB slave model.
// Covers the APB_TIMEOUT_EN build as well when that macro is defined.
module tb_apb_master_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK;
    logic          PRESET;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_strb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [3:0]    PSTRB;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        int            pselLen;
        logic [DW-1:0] rdata;
        logic          err;
        int            acceptCycle;
        int            lat;
    } xfer_t;

    xfer_t apbQ[$];
    xfer_t rspQ[$];

    int totalChecks = 0;
    int badChecks   = 0;
    int cycle       = 0;

    logic [DW-1:0] mem [16];
    int   slvWait;
    logic slvErr;
    logic idleReady;
    int   accCycle;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    // Slave: PREADY after slvWait ACCESS cycles; garbage data/error whenever not completing.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = (accCycle >= slvWait);
            accCycle++;
            PSLVERR = PREADY ? slvErr : 1'b1;
            PRDATA  = PREADY ? mem[PADDR[5:2]] : 32'hBADC0DE0;
            if (PREADY && PWRITE)
                for (int b = 0; b < 4; b++)
                    if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] = PWDATA[8*b +: 8];
        end else begin
            accCycle = 0;
            PREADY   = idleReady;
            PRDATA   = 32'hBADC0DE0;
            PSLVERR  = 1'b1;
        end
    end

    // APB-side monitor: request fields, PSEL length and idle gap between transfers.
    xfer_t cur;
    bit    inXfer = 0;
    bit    seenXfer = 0;
    int    pselCnt = 0;
    int    gapCnt = 0;
    always begin
        @(negedge PCLK);
        #1;
        if (PRESET) begin
            inXfer = 0;
            seenXfer = 0;
            pselCnt = 0;
        end else if (PSEL) begin
            if (!inXfer) begin
                if (apbQ.size() == 0) begin
                    checkOutput("apb_unexpected_psel", apbQ.size(), 1);
                end else begin
                    cur = apbQ.pop_front();
                    if (seenXfer) checkOutput("psel_gap_ge2", gapCnt >= 2, 1);
                    checkOutput("setup_penable", PENABLE, 0);
                end
                inXfer = 1;
                pselCnt = 1;
            end else begin
                pselCnt++;
                checkOutput("access_penable", PENABLE, 1);
            end
            checkOutput("paddr", PADDR, cur.addr);
            checkOutput("pwrite", PWRITE, cur.write);
            checkOutput("pwdata", PWDATA, cur.wdata);
            checkOutput("pstrb", PSTRB, cur.strb);
        end else begin
            if (inXfer) begin
                checkOutput("psel_len", pselCnt, cur.pselLen);
                checkOutput("penable_drop", PENABLE, 0);
                inXfer = 0;
                seenXfer = 1;
                gapCnt = 1;
            end else begin
                gapCnt++;
            end
        end
    end

    // Response-side monitor: latency on first valid cycle, payload on every valid cycle.
    bit prevValid = 0;
    always begin
        @(negedge PCLK);
        #1;
        if (PRESET) begin
            prevValid = 0;
        end else begin
            if (rsp_valid) begin
                checkOutput("rsp_vs_req_ready", req_ready, 0);
                if (rspQ.size() == 0) begin
                    checkOutput("rsp_unexpected", rspQ.size(), 1);
                end else begin
                    if (!prevValid)
                        checkOutput("rsp_latency", cycle + 1 - rspQ[0].acceptCycle, rspQ[0].lat);
                    checkOutput("rsp_rdata", rsp_rdata, rspQ[0].rdata);
                    checkOutput("rsp_err", rsp_err, rspQ[0].err);
                    if (rsp_ready) void'(rspQ.pop_front());
                end
            end
            prevValid = rsp_valid && !rsp_ready;
        end
    end

    task automatic applyStimulus(input logic write, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [3:0] strb,
                                 input int waitCycles, input logic [DW-1:0] expRdata,
                                 input logic expErr);
        xfer_t x;
        int n = 0;
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        while (!req_ready && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        x.addr        = addr;
        x.write       = write;
        x.wdata       = write ? wdata : '0;
        x.strb        = write ? strb : 4'h0;
        x.pselLen     = 2 + waitCycles;
        x.rdata       = expRdata;
        x.err         = expErr;
        x.acceptCycle = cycle + 1;
        x.lat         = 3 + waitCycles;
        apbQ.push_back(x);
        rspQ.push_back(x);
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge PCLK);
        PRESET = 1'b1;
        apbQ.delete();
        rspQ.delete();
        @(negedge PCLK);
        checkOutput("rst_psel", PSEL, 0);
        checkOutput("rst_penable", PENABLE, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        @(negedge PCLK);
        checkOutput("rst_pwrite", PWRITE, 0);
        checkOutput("rst_paddr", PADDR, 0);
        checkOutput("rst_pwdata", PWDATA, 0);
        checkOutput("rst_pstrb", PSTRB, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        PRESET = 1'b0;
        #1;
        checkOutput("post_rst_req_ready", req_ready, 1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (rspQ.size() != 0 && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("drain_pending", rspQ.size(), 0);
    endtask

    task automatic waitAccess();
        int n = 0;
        while (!(PSEL && PENABLE) && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("reach_access", PSEL && PENABLE, 1);
    endtask

    initial begin
        PRESET = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
        rsp_ready = 1'b1;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        slvWait = 0; slvErr = 1'b0; idleReady = 1'b1; accCycle = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[4] = 32'h12345678;
        mem[9] = 32'hFFFFFFFF;

        doReset();

        $display("[TB] write, zero wait states");
        applyStimulus(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        waitDrain();
        checkOutput("slave_mem_write", mem[1], 32'hDEADBEEF);

        $display("[TB] read, three wait states");
        slvWait = 3;
        applyStimulus(1'b0, 12'h010, 32'hA5A5A5A5, 4'hF, 3, 32'h12345678, 1'b0);
        waitDrain();

        $display("[TB] slave error with response backpressure");
        slvWait = 1;
        slvErr = 1'b1;
        mem[2] = 32'h0F0FA5A5;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 12'h008, 32'h0, 4'h0, 1, 32'h0F0FA5A5, 1'b1);
        begin
            int n = 0;
            while (!rsp_valid && n < 50) begin
                @(negedge PCLK);
                n++;
            end
            checkOutput("bp_valid_seen", rsp_valid, 1);
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid_hold", rsp_valid, 1);
            checkOutput("bp_err_hold", rsp_err, 1);
            checkOutput("bp_req_ready_low", req_ready, 0);
            @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        checkOutput("bp_idle_req_ready", req_ready, 1);
        checkOutput("bp_valid_cleared", rsp_valid, 0);
        slvErr = 1'b0;
        waitDrain();

        $display("[TB] back-to-back requests");
        slvWait = 0;
        applyStimulus(1'b1, 12'h020, 32'h11112222, 4'hF, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 12'h024, 32'h33334444, 4'h3, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 12'h020, 32'hCAFEF00D, 4'hF, 0, 32'h11112222, 1'b0);
        applyStimulus(1'b0, 12'h024, 32'hCAFEF00D, 4'hF, 0, 32'hFFFF4444, 1'b0);
        waitDrain();

        $display("[TB] PREADY arriving on the wait-limit cycle");
        slvWait = TO;
        applyStimulus(1'b0, 12'h010, 32'h0, 4'h0, TO, 32'h12345678, 1'b0);
        waitDrain();

        slvWait = 1000;
`ifdef APB_TIMEOUT_EN
        $display("[TB] stalled slave, timeout enabled");
        applyStimulus(1'b0, 12'h00C, 32'h0, 4'h0, TO, 32'h0, 1'b1);
        waitDrain();
`else
        $display("[TB] stalled slave, timeout disabled");
        applyStimulus(1'b0, 12'h00C, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        repeat (100) @(negedge PCLK);
        checkOutput("stall_psel", PSEL, 1);
        checkOutput("stall_penable", PENABLE, 1);
        checkOutput("stall_rsp_valid", rsp_valid, 0);
        checkOutput("stall_paddr", PADDR, 12'h00C);
        doReset();
`endif

        $display("[TB] reset during ACCESS");
        applyStimulus(1'b0, 12'h018, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        waitAccess();
        @(negedge PCLK);
        doReset();
        repeat (10) @(negedge PCLK);
        checkOutput("no_rsp_after_reset", rsp_valid, 0);

        $display("[TB] transfer after reset");
        slvWait = 1;
        applyStimulus(1'b1, 12'h000, 32'h01020304, 4'hF, 1, 32'h0, 1'b0);
        waitDrain();
        checkOutput("post_reset_mem", mem[0], 32'h01020304);
        checkOutput("apb_pending", apbQ.size(), 0);

        repeat (3) @(negedge PCLK);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", totalChecks, badChecks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
